// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: transfer direction encoding,
// responder FSM state encoding and the data pattern returned on faults.
package cpu_bus_pkg;

  // Transfer direction, same encoding the control unit drives on read_write
  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  // Wait-state counter width; covers the legal WAIT_STATES range 0..15
  localparam int WAIT_CNT_W = 4;

  // Returned on an out-of-range read; sliced down to the bus data width
  localparam logic [63:0] FAULT_DATA_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_responder_if.sv
// CPU-to-memory request/response bundle. The CPU side is the master, the
// memory responder is the slave.
interface bus_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);

  logic                  req;
  logic                  read_write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  fault;

  modport master (
    output req,
    output read_write,
    output address,
    output data_in,
    input  data_out,
    input  ready,
    input  fault
  );

  modport slave (
    input  req,
    input  read_write,
    input  address,
    input  data_in,
    output data_out,
    output ready,
    output fault
  );

endinterface

// File: rtl/bus_ram.sv
// Single-port synchronous RAM with a registered, enable-gated read port.
// Array contents are never reset; only the read register is, so the
// responder's data_out comes up as zero.
module bus_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write port: storage only, no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value until the next enabled read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: latches a CPU request, waits a fixed number of
// cycles, commits the access to the internal RAM and answers with a
// one-cycle ready strobe. Addresses beyond the RAM raise fault.
//
// state   | meaning
// IDLE    | waiting for req; latches address/direction/data when it arrives
// WAIT    | counting down wait states; commits the access when count is 0
// RESP    | ready (and fault if flagged) high for this single cycle
module bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  bus_responder_if.slave  bus
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] FAULT_DATA = FAULT_DATA_ALL[DATA_WIDTH-1:0];

  bus_state_e            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q;
  logic                  fault_q;
  logic                  rd_fault_q;

  logic                  in_range;
  logic                  commit;
  logic                  ram_we;
  logic                  ram_re;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Range check and RAM strobes, all derived from the latched request
  always_comb begin
    in_range = ({1'b0, addr_q} < DEPTH_EXT);
    commit   = (state == ST_WAIT) && (wait_cnt == '0);
    ram_we   = commit && (rw_q == BUS_WRITE) && in_range;
    ram_re   = commit && (rw_q == BUS_READ) && in_range;
    ram_addr = addr_q[RAM_AW-1:0];
  end

  bus_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Request FSM with wait counter, input latches and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      rw_q       <= BUS_READ;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      rd_fault_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q   <= bus.address;
            rw_q     <= bus.read_write;
            wdata_q  <= bus.data_in;
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            state   <= ST_RESP;
            ready_q <= 1'b1;
            fault_q <= !in_range;
            // Only reads decide what data_out shows; writes leave it alone
            if (rw_q == BUS_READ) begin
              rd_fault_q <= !in_range;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // data_out is the held RAM read word, or all-ones after a faulting read
  always_comb begin
    bus.data_out = rd_fault_q ? FAULT_DATA : ram_rdata;
    bus.ready    = ready_q;
    bus.fault    = fault_q;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with three instances (0, 1 and 3 wait
// states). Expected responses are queued when a request is driven and
// checked when ready appears.
module tb_bus_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bi0 ();
  bus_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bi1 ();
  bus_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bi3 ();

  bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bi0));
  bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(1))
    dut1 (.clk(clk), .rst(rst), .bus(bi1));
  bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(3))
    dut3 (.clk(clk), .rst(rst), .bus(bi3));

  typedef struct {
    logic [7:0] data;
    logic       fault;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [3][256];
  logic [7:0] last_rd [3];
  int         n_assert = 0;
  int         n_fail   = 0;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(int sel);
    return (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
  endfunction

  task automatic drive(int sel, logic r, logic rw, logic [15:0] a, logic [7:0] d);
    case (sel)
      0:       begin bi0.req = r; bi0.read_write = rw; bi0.address = a; bi0.data_in = d; end
      1:       begin bi1.req = r; bi1.read_write = rw; bi1.address = a; bi1.data_in = d; end
      default: begin bi3.req = r; bi3.read_write = rw; bi3.address = a; bi3.data_in = d; end
    endcase
  endtask

  task automatic sample(int sel, output logic rdy, output logic flt, output logic [7:0] dout);
    case (sel)
      0:       begin rdy = bi0.ready; flt = bi0.fault; dout = bi0.data_out; end
      1:       begin rdy = bi1.ready; flt = bi1.fault; dout = bi1.data_out; end
      default: begin rdy = bi3.ready; flt = bi3.fault; dout = bi3.data_out; end
    endcase
  endtask

  // Reference model: returns the expected response and updates model state
  function automatic exp_t model(int sel, logic rw, logic [15:0] a, logic [7:0] d);
    exp_t e;
    logic in_r;
    in_r = (a < 16'd256);
    if (rw == WR) begin
      if (in_r) mem_m[sel][a[7:0]] = d;
      e.data = last_rd[sel];
    end else begin
      e.data = in_r ? mem_m[sel][a[7:0]] : 8'hFF;
      last_rd[sel] = e.data;
    end
    e.fault = !in_r;
    e.lat   = ws_of(sel) + 2;
    return e;
  endfunction

  task automatic check_resp(string tag, int sel, int edges);
    exp_t e;
    logic rdy, flt;
    logic [7:0] dout;
    sample(sel, rdy, flt, dout);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(dout), 32'(e.data));
      chk({tag, "_fault"}, 32'(flt), 32'(e.fault));
      chk({tag, "_latency"}, 32'(edges), 32'(e.lat));
    end
  endtask

  // One complete transaction with req dropped after the sampling edge
  task automatic txn(string tag, int sel, logic rw, logic [15:0] a, logic [7:0] d);
    int edges;
    bit seen;
    logic rdy, flt;
    logic [7:0] dout;
    sb.push_back(model(sel, rw, a, d));
    @(negedge clk);
    drive(sel, 1'b1, rw, a, d);
    edges = 0;
    seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) drive(sel, 1'b0, rw, a, d);
      sample(sel, rdy, flt, dout);
      if (rdy) seen = 1;
    end
    chk({tag, "_ready_seen"}, 32'(seen), 1);
    if (seen) begin
      check_resp(tag, sel, edges);
      @(posedge clk);
      @(negedge clk);
      sample(sel, rdy, flt, dout);
      chk({tag, "_ready_width"}, 32'(rdy), 0);
      chk({tag, "_fault_width"}, 32'(flt), 0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int edges;
    bit seen;
    logic rdy, flt;
    logic [7:0] dout;

    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, RD, 16'h0000, 8'h00);
      last_rd[s] = 8'h00;
    end

    // Reset values while reset is held
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sample(1, rdy, flt, dout);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_fault", 32'(flt), 0);
    chk("rst_dout", 32'(dout), 0);
    rst = 1'b0;

    // Basic write then read
    txn("wr_10", 1, WR, 16'h0010, 8'h5A);
    txn("rd_10", 1, RD, 16'h0010, 8'h00);

    // Out of range with no aliasing onto address 0
    txn("wr_00", 1, WR, 16'h0000, 8'h3C);
    txn("rd_100", 1, RD, 16'h0100, 8'h00);
    txn("wr_100", 1, WR, 16'h0100, 8'h77);
    txn("rd_00", 1, RD, 16'h0000, 8'h00);

    // Writes must not disturb data_out
    txn("wr_40", 1, WR, 16'h0040, 8'hAA);
    txn("rd_40", 1, RD, 16'h0040, 8'h00);
    txn("wr_41", 1, WR, 16'h0041, 8'h55);

    // Wait-state sweep
    txn("w0_wr", 0, WR, 16'h0005, 8'h12);
    txn("w0_rd", 0, RD, 16'h0005, 8'h00);
    txn("w3_wr", 2, WR, 16'h0007, 8'h34);
    txn("w3_rd", 2, RD, 16'h0007, 8'h00);
    txn("w3_oob", 2, RD, 16'hFFFF, 8'h00);

    // Held req: two back-to-back reads; address changes in the second WAIT
    txn("wr_50", 1, WR, 16'h0050, 8'h01);
    txn("wr_20", 1, WR, 16'h0020, 8'h9E);
    sb.push_back(model(1, RD, 16'h0020, 8'h00));
    sb.push_back(model(1, RD, 16'h0020, 8'h00));
    @(negedge clk);
    drive(1, 1'b1, RD, 16'h0020, 8'h00);
    edges = 0;
    seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      sample(1, rdy, flt, dout);
      if (rdy) seen = 1;
    end
    chk("held1_ready_seen", 32'(seen), 1);
    check_resp("held1", 1, edges);
    edges = 0;
    seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 2) drive(1, 1'b0, RD, 16'h0050, 8'h00);
      sample(1, rdy, flt, dout);
      if (rdy) seen = 1;
    end
    chk("held2_ready_seen", 32'(seen), 1);
    chk("held2_spacing", 32'(edges), 32'(ws_of(1) + 3));
    sample(1, rdy, flt, dout);
    chk("held2_data", 32'(dout), 32'h9E);
    chk("held2_fault", 32'(flt), 0);
    sb.delete();

    // Reset during WAIT of a write: the write must never land
    txn("wr_30", 1, WR, 16'h0030, 8'h11);
    @(negedge clk);
    drive(1, 1'b1, WR, 16'h0030, 8'hC3);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, WR, 16'h0030, 8'hC3);
    rst = 1'b1;
    #1;
    sample(1, rdy, flt, dout);
    chk("midrst_ready", 32'(rdy), 0);
    chk("midrst_fault", 32'(flt), 0);
    chk("midrst_dout", 32'(dout), 0);
    for (int s = 0; s < 3; s++) last_rd[s] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    txn("rd_30", 1, RD, 16'h0030, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
